// File: rtl/ahb_stream_loader.sv
// AHB-Lite write master that packs a byte stream into little-endian words
// and stores them one NONSEQ transfer at a time from a programmable base.
module ahb_stream_loader #(
  parameter int AW = 16,
  parameter int LW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] word_count,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          HRESP
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ADDR, S_DATA, S_FIN
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_remain;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_pack;
  logic [31:0]   r_hwdata;
  logic          r_busy, r_done, r_error;
  logic          w_take_start, w_accept, w_xfer_done, w_abort;

  assign w_take_start = (r_state == S_IDLE) & start;
  assign w_accept     = (r_state == S_COLLECT) & s_valid;
  assign w_xfer_done  = (r_state == S_DATA) & HREADY;
  // ERROR may show in either response cycle; r_error remembers the first one
  assign w_abort      = r_error | HRESP;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (word_count == '0) ? S_FIN : S_COLLECT;
      S_COLLECT: if (s_valid && r_byte_idx == 2'd3) w_next = S_ADDR;
      S_ADDR:    if (HREADY) w_next = S_DATA;
      S_DATA:    if (HREADY) w_next = (w_abort || r_remain == LW'(1)) ? S_FIN : S_COLLECT;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_byte_idx <= '0;
      r_pack     <= '0;
      r_hwdata   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      if (r_state == S_FIN) r_busy <= 1'b0;

      if (w_take_start) begin
        r_addr     <= base_addr & ~AW'(3);
        r_remain   <= word_count;
        r_byte_idx <= '0;
        r_error    <= 1'b0;
        r_busy     <= 1'b1;
      end

      if (w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_pack[7:0]   <= s_data;
          2'd1:    r_pack[15:8]  <= s_data;
          2'd2:    r_pack[23:16] <= s_data;
          default: r_hwdata      <= {s_data, r_pack};
        endcase
      end

      if (r_state == S_DATA && HRESP) r_error <= 1'b1;

      // address wraps naturally at 2^AW
      if (w_xfer_done && !w_abort) begin
        r_addr   <= r_addr + AW'(4);
        r_remain <= r_remain - LW'(1);
      end
    end
  end

  assign s_ready = (r_state == S_COLLECT);
  assign HTRANS  = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE  = (r_state == S_ADDR);
  assign HADDR   = r_addr;
  assign HSIZE   = 3'b010;
  assign HWDATA  = r_hwdata;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;

endmodule
